gen_row_streamer: RTL

- Sits directly downstream of the cell array.
- Snapshots the flat state vector of all cells when the generation strobe fires.
- Streams the snapshot out one row per transfer over a valid/ready handshake to the display/readout logic.
- Accumulates the live-cell population and a generation counter while it streams.

---
 rtl/gen_row_streamer.sv | 136 +++++++++++++
 1 files changed

// File: rtl/gen_row_streamer.sv
// Captures the cell array on a generation strobe and streams it out row by row,
// counting live cells and completed generations. Define STILL_LIFE_DETECT_EN for still-life flagging.
module gen_row_streamer #(
    parameter int ROWS  = 8,
    parameter int COLS  = 8,
    parameter int GEN_W = 16,
    localparam int IDX_W = (ROWS > 2) ? $clog2(ROWS) : 1,
    localparam int CNT_W = $clog2(ROWS * COLS + 1)
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic [ROWS*COLS-1:0] grid_state,
    input  logic                 snap,
    output logic [COLS-1:0]      row_data,
    output logic [IDX_W-1:0]     row_idx,
    output logic                 row_valid,
    input  logic                 row_ready,
    output logic                 frame_last,
    output logic                 busy,
    output logic                 frame_drop,
    output logic [CNT_W-1:0]     live_count,
    output logic [GEN_W-1:0]     gen_count,
    output logic                 still_life
);

    typedef enum logic {IDLE = 1'b0, STREAM = 1'b1} state_t;

    state_t               state_q, state_d;
    logic [ROWS*COLS-1:0] snap_q;
    logic [IDX_W-1:0]     ptr_q;
    logic [CNT_W-1:0]     acc_q;
    logic [CNT_W-1:0]     live_q;
    logic [CNT_W-1:0]     row_pop;
    logic [CNT_W-1:0]     acc_sum;
    logic [GEN_W-1:0]     gen_q;
    logic                 drop_q;
    logic                 xfer;
    logic [COLS-1:0]      cur_row;
    logic [COLS-1:0]      rows [ROWS];

    function automatic logic [CNT_W-1:0] popcount(input logic [COLS-1:0] v);
        logic [CNT_W-1:0] n;
        n = '0;
        for (int i = 0; i < COLS; i++) n = n + CNT_W'(v[i]);
        return n;
    endfunction

    always_comb begin
        for (int r = 0; r < ROWS; r++) rows[r] = snap_q[r*COLS +: COLS];
    end

    assign cur_row = rows[ptr_q];
    assign row_pop = popcount(cur_row);
    assign acc_sum = acc_q + row_pop;

    // Handshake: a row moves on every rising edge where row_valid & row_ready; until then
    // row_data/row_idx are held. busy mirrors the STREAM state of the FSM.
    always_comb begin
        state_d    = state_q;
        row_valid  = 1'b0;
        busy       = 1'b0;
        frame_last = 1'b0;
        xfer       = 1'b0;
        case (state_q)
            IDLE: begin
                if (snap) state_d = STREAM;
            end
            STREAM: begin
                row_valid  = 1'b1;
                busy       = 1'b1;
                frame_last = (ptr_q == IDX_W'(ROWS - 1));
                xfer       = row_ready;
                if (row_ready && frame_last) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q <= IDLE;
            snap_q  <= '0;
            ptr_q   <= '0;
            acc_q   <= '0;
            live_q  <= '0;
            gen_q   <= '0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            drop_q  <= snap && busy;
            if (state_q == IDLE && snap) begin
                snap_q <= grid_state;
                ptr_q  <= '0;
                acc_q  <= '0;
            end
            if (xfer) begin
                if (frame_last) begin
                    // Pointer parks at row 0 so the idle index never leaves the grid.
                    ptr_q  <= '0;
                    acc_q  <= '0;
                    live_q <= acc_sum;
                    gen_q  <= gen_q + 1'b1;
                end else begin
                    ptr_q <= ptr_q + 1'b1;
                    acc_q <= acc_sum;
                end
            end
        end
    end

    assign row_data   = row_valid ? cur_row : '0;
    assign row_idx    = ptr_q;
    assign frame_drop = drop_q;
    assign live_count = live_q;
    assign gen_count  = gen_q;

`ifdef STILL_LIFE_DETECT_EN
    logic [ROWS*COLS-1:0] prev_q;
    logic                 still_q;

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            prev_q  <= '0;
            still_q <= 1'b0;
        end else if (xfer && frame_last) begin
            still_q <= (snap_q == prev_q);
            prev_q  <= snap_q;
        end
    end

    assign still_life = still_q;
`else
    assign still_life = 1'b0;
`endif

endmodule
